// File: rtl/syndrome_t3_gf10_seq_if.sv
// ============================================================================
//  syndrome_t3_gf10_seq_if
//  Bit-stream input and syndrome output bundle for the t=3 syndrome generator.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface syndrome_t3_gf10_seq_if #(
    parameter int GF_LEN = 10
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ctr_flush;
    logic              out_ctr_en;
    logic              out_ctr_done;
    logic [GF_LEN-1:0] out_synd1;
    logic [GF_LEN-1:0] out_synd3;
    logic [GF_LEN-1:0] out_synd5;
    logic              out_zero;

    modport master (
        output in_valid, in_bit, in_ctr_flush,
        input  out_ctr_en, out_ctr_done, out_synd1, out_synd3, out_synd5, out_zero
    );

    modport slave (
        input  in_valid, in_bit, in_ctr_flush,
        output out_ctr_en, out_ctr_done, out_synd1, out_synd3, out_synd5, out_zero
    );
endinterface

`default_nettype wire

// File: rtl/syndrome_t3_gf10_seq.sv
// ============================================================================
//  syndrome_t3_gf10_seq
//  Bit-serial S1/S3/S5 syndrome generator, t=3 BCH over GF(2^10).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module syndrome_t3_gf10_seq #(
    parameter int GF_LEN     = 10,
    parameter int CW_LEN     = 1023,
    parameter int KEY_EQ_BUF = 8
) (
    input  logic                    clk,
    input  logic                    in_ctr_Srst_n,
    syndrome_t3_gf10_seq_if.slave   bus
);
    localparam int BW  = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
    localparam int CWW = (KEY_EQ_BUF > 1) ? $clog2(KEY_EQ_BUF) : 1;

    localparam logic [BW-1:0]     c_last_bit = BW'(CW_LEN - 1);
    localparam logic [CWW-1:0]    c_last_cw  = CWW'(KEY_EQ_BUF - 1);
    // Low-order terms of x^10 = x^3 + 1 fed back when the top bit shifts out
    localparam logic [GF_LEN-1:0] c_poly_low = GF_LEN'(9);

    generate
        if (GF_LEN != 10) begin : g_bad_gf_len
            $error("syndrome_t3_gf10_seq: GF_LEN must be 10");
        end
        if (CW_LEN < 2 || CW_LEN > 1023) begin : g_bad_cw_len
            $error("syndrome_t3_gf10_seq: CW_LEN must be in 2..1023");
        end
        if (KEY_EQ_BUF < 1) begin : g_bad_key_eq_buf
            $error("syndrome_t3_gf10_seq: KEY_EQ_BUF must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } phase_t;

    function automatic logic [GF_LEN-1:0] mul_alpha_n(
        input logic [GF_LEN-1:0] a,
        input int                n
    );
        logic [GF_LEN-1:0] v;
        v = a;
        for (int k = 0; k < n; k++) begin
            v = {v[GF_LEN-2:0], 1'b0} ^ (v[GF_LEN-1] ? c_poly_low : '0);
        end
        return v;
    endfunction

    logic [GF_LEN-1:0] r_acc1, r_acc3, r_acc5;
    logic [BW-1:0]     r_bit_cnt;
    logic [CWW-1:0]    r_cw_cnt;
    logic [GF_LEN-1:0] r_synd1, r_synd3, r_synd5;
    logic              r_zero, r_en, r_done;

    logic [GF_LEN-1:0] w_acc1_nxt, w_acc3_nxt, w_acc5_nxt;
    logic [BW-1:0]     w_bit_cnt_nxt;
    logic [CWW-1:0]    w_cw_cnt_nxt;
    logic [GF_LEN-1:0] w_synd1_nxt, w_synd3_nxt, w_synd5_nxt;
    logic              w_zero_nxt, w_en_nxt, w_done_nxt;

    logic [GF_LEN-1:0] w_in_ext;
    logic [GF_LEN-1:0] w_h1, w_h3, w_h5;
    phase_t            w_phase;
    logic              w_last;

    assign w_in_ext = GF_LEN'(bus.in_bit);
    assign w_h1     = mul_alpha_n(r_acc1, 1) ^ w_in_ext;
    assign w_h3     = mul_alpha_n(r_acc3, 3) ^ w_in_ext;
    assign w_h5     = mul_alpha_n(r_acc5, 5) ^ w_in_ext;
    assign w_phase  = (r_bit_cnt == '0) ? IDLE : ACCUM;
    assign w_last   = (r_bit_cnt == c_last_bit);

    always_comb begin
        w_acc1_nxt    = r_acc1;
        w_acc3_nxt    = r_acc3;
        w_acc5_nxt    = r_acc5;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cw_cnt_nxt  = r_cw_cnt;
        w_synd1_nxt   = r_synd1;
        w_synd3_nxt   = r_synd3;
        w_synd5_nxt   = r_synd5;
        w_zero_nxt    = r_zero;
        w_en_nxt      = 1'b0;
        w_done_nxt    = 1'b0;

        // Flush beats a coincident valid bit, including the final one
        if (bus.in_ctr_flush) begin
            w_bit_cnt_nxt = '0;
        end else if (bus.in_valid) begin
            if (w_phase == IDLE) begin
                w_acc1_nxt    = w_in_ext;
                w_acc3_nxt    = w_in_ext;
                w_acc5_nxt    = w_in_ext;
                w_bit_cnt_nxt = BW'(1);
            end else begin
                w_acc1_nxt = w_h1;
                w_acc3_nxt = w_h3;
                w_acc5_nxt = w_h5;
                if (w_last) begin
                    w_synd1_nxt   = w_h1;
                    w_synd3_nxt   = w_h3;
                    w_synd5_nxt   = w_h5;
                    w_zero_nxt    = (w_h1 == '0) && (w_h3 == '0) && (w_h5 == '0);
                    w_en_nxt      = 1'b1;
                    w_done_nxt    = (r_cw_cnt == c_last_cw);
                    w_cw_cnt_nxt  = (r_cw_cnt == c_last_cw) ? '0 : r_cw_cnt + CWW'(1);
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            r_acc1    <= '0;
            r_acc3    <= '0;
            r_acc5    <= '0;
            r_bit_cnt <= '0;
            r_cw_cnt  <= '0;
            r_synd1   <= '0;
            r_synd3   <= '0;
            r_synd5   <= '0;
            r_zero    <= 1'b0;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_acc1    <= w_acc1_nxt;
            r_acc3    <= w_acc3_nxt;
            r_acc5    <= w_acc5_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cw_cnt  <= w_cw_cnt_nxt;
            r_synd1   <= w_synd1_nxt;
            r_synd3   <= w_synd3_nxt;
            r_synd5   <= w_synd5_nxt;
            r_zero    <= w_zero_nxt;
            r_en      <= w_en_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.out_ctr_en   = r_en;
    assign bus.out_ctr_done = r_done;
    assign bus.out_synd1    = r_synd1;
    assign bus.out_synd3    = r_synd3;
    assign bus.out_synd5    = r_synd5;
    assign bus.out_zero     = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_syndrome_t3_gf10_seq.sv
// ============================================================================
//  tb_syndrome_t3_gf10_seq
//  Directed bench for the syndrome generator with a power-table syndrome model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_syndrome_t3_gf10_seq;
    localparam int GF_LEN     = 10;
    localparam int CW_LEN     = 1023;
    localparam int KEY_EQ_BUF = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    syndrome_t3_gf10_seq_if #(.GF_LEN(GF_LEN)) bus ();

    syndrome_t3_gf10_seq #(
        .GF_LEN    (GF_LEN),
        .CW_LEN    (CW_LEN),
        .KEY_EQ_BUF(KEY_EQ_BUF)
    ) dut (
        .clk          (clk),
        .in_ctr_Srst_n(rst_n),
        .bus          (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [9:0] s1, s3, s5;
        logic       z, d;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       held;
    exp_t       e;
    logic       chk_on = 1'b0;
    int         batch_pos = 0;
    int         last_pulse = -1;
    logic [9:0] pw [0:CW_LEN-1];
    bit         cw [0:CW_LEN-1];

    // Field arithmetic: polynomial-basis multiply reduced by x^10+x^3+1
    function automatic logic [9:0] xtime(input logic [9:0] a);
        return {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    endfunction

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S_i = XOR of alpha^(i*deg) over every set coefficient
    task automatic model_synd(output logic [9:0] s1, output logic [9:0] s3, output logic [9:0] s5);
        s1 = '0; s3 = '0; s5 = '0;
        for (int d = 0; d < CW_LEN; d++) begin
            if (cw[d]) begin
                s1 ^= pw[d % 1023];
                s3 ^= pw[(3 * d) % 1023];
                s5 ^= pw[(5 * d) % 1023];
            end
        end
    endtask

    task automatic expect_cw();
        exp_t x;
        model_synd(x.s1, x.s3, x.s5);
        x.z = (x.s1 == 0) && (x.s3 == 0) && (x.s5 == 0);
        x.d = (batch_pos == KEY_EQ_BUF - 1);
        batch_pos = (batch_pos + 1) % KEY_EQ_BUF;
        x.cyc = cyc;
        q.push_back(x);
    endtask

    task automatic drive(input logic v, input logic b, input logic f);
        bus.in_valid     = v;
        bus.in_bit       = b;
        bus.in_ctr_flush = f;
        @(posedge clk);
        #1;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.in_ctr_flush = 1'b0;
    endtask

    task automatic clear_model();
        q.delete();
        batch_pos  = 0;
        last_pulse = -1;
        held       = '{s1: 0, s3: 0, s5: 0, z: 0, d: 0, cyc: 0};
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // flush_at >= 0 asserts flush together with the bit of that degree and stops
    task automatic send_cw(input bit gaps, input int flush_at);
        for (int d = CW_LEN - 1; d >= 0; d--) begin
            if (gaps) while ($urandom_range(0, 1) == 0) drive(1'b0, 1'b0, 1'b0);
            if (d == flush_at) begin
                drive(1'b1, cw[d], 1'b1);
                return;
            end
            drive(1'b1, cw[d], 1'b0);
        end
        expect_cw();
    endtask

    task automatic set_single(input int deg);
        for (int d = 0; d < CW_LEN; d++) cw[d] = 1'b0;
        if (deg >= 0) cw[deg] = 1'b1;
    endtask

    task automatic set_random();
        for (int d = 0; d < CW_LEN; d++) cw[d] = 1'($urandom_range(0, 1));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (bus.out_ctr_en) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: out_ctr_en=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("synd1", 32'(bus.out_synd1), 32'(e.s1));
                    chk("synd3", 32'(bus.out_synd3), 32'(e.s3));
                    chk("synd5", 32'(bus.out_synd5), 32'(e.s5));
                    chk("zero", 32'(bus.out_zero), 32'(e.z));
                    chk("done", 32'(bus.out_ctr_done), 32'(e.d));
                    if (last_pulse >= 0) chk("pulse_spacing", 32'((cyc - last_pulse) >= CW_LEN), 1);
                    last_pulse = cyc;
                    held = e;
                end
            end else begin
                if (q.size() > 0 && cyc > q[0].cyc) begin
                    chk("missing_pulse", 0, 1);
                    void'(q.pop_front());
                end
                chk("done_without_en", 32'(bus.out_ctr_done), 0);
                chk("hold_synd1", 32'(bus.out_synd1), 32'(held.s1));
                chk("hold_synd3", 32'(bus.out_synd3), 32'(held.s3));
                chk("hold_synd5", 32'(bus.out_synd5), 32'(held.s5));
                chk("hold_zero", 32'(bus.out_zero), 32'(held.z));
            end
        end
    end

    initial begin
        #5_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [9:0] m1, m3, m5;

        pw[0] = 10'h001;
        for (int k = 1; k < CW_LEN; k++) pw[k] = gf_mul(pw[k-1], 10'h002);

        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.in_ctr_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        chk_on = 1'b1;

        // Hand-derived field values that pin the model
        chk("model_alpha3", 32'(pw[3]), 32'h008);
        chk("model_alpha10", 32'(pw[10]), 32'h009);
        chk("model_alpha1023", 32'(gf_mul(pw[1022], 10'h002)), 32'h001);

        @(negedge clk);
        chk("reset_en", 32'(bus.out_ctr_en), 0);
        chk("reset_synd1", 32'(bus.out_synd1), 0);
        chk("reset_zero", 32'(bus.out_zero), 0);

        // All-zero, then single ones at degree 0, 1, 10, back to back
        set_single(-1);
        send_cw(1'b0, -1);
        set_single(0);
        model_synd(m1, m3, m5);
        chk("model_deg0", {2'b0, m1, m3, m5}, {2'b0, 10'h001, 10'h001, 10'h001});
        send_cw(1'b0, -1);
        set_single(1);
        model_synd(m1, m3, m5);
        chk("model_deg1", {2'b0, m1, m3, m5}, {2'b0, 10'h002, 10'h008, 10'h020});
        send_cw(1'b0, -1);
        set_single(10);
        model_synd(m1, m3, m5);
        chk("model_deg10", {2'b0, m1, m3, m5}, {2'b0, 10'h009, 10'h249, 10'h10D});
        send_cw(1'b0, -1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Full batch plus one, back to back
        do_reset(2);
        for (int n = 0; n < KEY_EQ_BUF + 1; n++) begin
            set_random();
            send_cw(1'b0, -1);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a codeword
        set_random();
        for (int d = CW_LEN - 1; d >= 623; d--) drive(1'b1, cw[d], 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_en", 32'(bus.out_ctr_en), 0);
        chk("midrst_done", 32'(bus.out_ctr_done), 0);
        chk("midrst_synd1", 32'(bus.out_synd1), 0);
        chk("midrst_synd3", 32'(bus.out_synd3), 0);
        chk("midrst_synd5", 32'(bus.out_synd5), 0);
        chk("midrst_zero", 32'(bus.out_zero), 0);

        // Batch restarts at 0: six plain, one with gaps, then flushes before the 8th
        for (int n = 0; n < 6; n++) begin
            set_random();
            send_cw(1'b0, -1);
        end
        set_random();
        send_cw(1'b1, -1);
        set_random();
        send_cw(1'b0, 0);
        set_random();
        send_cw(1'b0, 600);
        drive(1'b0, 1'b0, 1'b0);
        set_random();
        send_cw(1'b0, -1);

        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("drain_queue", 32'(q.size()), 0);
        chk("batch_pos_final", 32'(batch_pos), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
